// File: rtl/stage5_writeback_if.sv
// Writeback-stage bus: memory-stage result in, register-file write port plus debug state out.
// The master modport belongs to the upstream stage; the writeback stage uses the slave modport.
interface stage5_writeback_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
);
  // Memory-stage side
  logic                  En_Pipeline;
  logic                  STG4_Valid;
  logic [5:0]            STG4_opcode;
  logic [DATA_WIDTH-1:0] STG4_ALU_result;
  logic [DATA_WIDTH-1:0] STG4_Mem_data;
  logic                  STG4_Mem_Read;
  logic [ADDR_WIDTH-1:0] STG4_Addr_Write_Reg;
  logic                  STG4_En_Write_Reg;

  // Register-file write port
  logic [DATA_WIDTH-1:0] STG25_data_in;
  logic [ADDR_WIDTH-1:0] STG25_addr_Write_Reg;
  logic                  STG25_En_Write_Reg;

  // Previous-write copy and debug counters
  logic                  Fwd_Valid;
  logic [ADDR_WIDTH-1:0] Fwd_Addr;
  logic [DATA_WIDTH-1:0] Fwd_Data;
  logic [CNT_WIDTH-1:0]  Retired_Count;
  logic [CNT_WIDTH-1:0]  Write_Count;

  modport master (
    output En_Pipeline,
    output STG4_Valid,
    output STG4_opcode,
    output STG4_ALU_result,
    output STG4_Mem_data,
    output STG4_Mem_Read,
    output STG4_Addr_Write_Reg,
    output STG4_En_Write_Reg,
    input  STG25_data_in,
    input  STG25_addr_Write_Reg,
    input  STG25_En_Write_Reg,
    input  Fwd_Valid,
    input  Fwd_Addr,
    input  Fwd_Data,
    input  Retired_Count,
    input  Write_Count
  );

  modport slave (
    input  En_Pipeline,
    input  STG4_Valid,
    input  STG4_opcode,
    input  STG4_ALU_result,
    input  STG4_Mem_data,
    input  STG4_Mem_Read,
    input  STG4_Addr_Write_Reg,
    input  STG4_En_Write_Reg,
    output STG25_data_in,
    output STG25_addr_Write_Reg,
    output STG25_En_Write_Reg,
    output Fwd_Valid,
    output Fwd_Addr,
    output Fwd_Data,
    output Retired_Count,
    output Write_Count
  );
endinterface

// File: rtl/stage5_writeback.sv
// MIPS writeback stage: registers the memory-stage result, qualifies the register write and
// keeps a one-cycle-delayed copy of the last write plus retire/write debug counters.
module stage5_writeback #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               reset,
  stage5_writeback_if.slave  wb
);

  localparam logic [5:0] OpStw = 6'h02;
  localparam logic [5:0] OpBeq = 6'h0C;
  localparam logic [5:0] OpBne = 6'h0D;
  localparam logic [5:0] OpBgt = 6'h0E;
  localparam logic [5:0] OpBle = 6'h0F;
  localparam logic [5:0] OpJmp = 6'h3F;

  logic                  w_no_write_op;
  logic                  w_qw;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_en;
  logic                  r_fwd_valid;
  logic [ADDR_WIDTH-1:0] r_fwd_addr;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [CNT_WIDTH-1:0]  r_retired;
  logic [CNT_WIDTH-1:0]  r_writes;

  // Stores, branches and jumps never write the register file, whatever decode requested.
  always_comb begin
    w_no_write_op = 1'b0;
    case (wb.STG4_opcode)
      OpStw, OpBeq, OpBne, OpBgt, OpBle, OpJmp: w_no_write_op = 1'b1;
      default:                                  w_no_write_op = 1'b0;
    endcase
  end

  assign w_sel_data = wb.STG4_Mem_Read ? wb.STG4_Mem_data : wb.STG4_ALU_result;

  assign w_qw = wb.STG4_Valid & wb.STG4_En_Write_Reg &
                (wb.STG4_Addr_Write_Reg != '0) & ~w_no_write_op;

  // Stage register; a stall holds data/address but drops enable so a write issues only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_addr <= '0;
      r_en   <= 1'b0;
    end else if (wb.En_Pipeline) begin
      r_data <= w_sel_data;
      r_addr <= wb.STG4_Addr_Write_Reg;
      r_en   <= w_qw;
    end else begin
      r_en   <= 1'b0;
    end
  end

  // Copy of the write the register file is performing this edge, for a future hazard unit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= r_en;
      if (r_en) begin
        r_fwd_addr <= r_addr;
        r_fwd_data <= r_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
      r_writes  <= '0;
    end else if (wb.En_Pipeline) begin
      if (wb.STG4_Valid) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
      if (w_qw) begin
        r_writes <= r_writes + CNT_WIDTH'(1);
      end
    end
  end

  assign wb.STG25_data_in        = r_data;
  assign wb.STG25_addr_Write_Reg = r_addr;
  assign wb.STG25_En_Write_Reg   = r_en;
  assign wb.Fwd_Valid            = r_fwd_valid;
  assign wb.Fwd_Addr             = r_fwd_addr;
  assign wb.Fwd_Data             = r_fwd_data;
  assign wb.Retired_Count        = r_retired;
  assign wb.Write_Count          = r_writes;

endmodule

// File: doc/stage5_writeback.md
# stage5_writeback

Writeback stage of the 5-stage MIPS pipeline: the driving end of the decode stage's register-file write port. It registers the memory-stage result, selects load data or ALU result, qualifies the write enable, and presents data, address and enable to the decode stage's register file. It also keeps a one-cycle-delayed copy of the last write for a future hazard unit, plus retire/write counters for debug.

## Interface
- DATA_WIDTH, 32, register-file data width
- ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 32, width of both debug counters
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- En_Pipeline  in  1  pipeline advance enable; 0 = stall
- STG4_Valid  in  1  memory stage holds a real instruction (0 = bubble)
- STG4_opcode  in  6  opcode of the instruction in the memory stage
- STG4_ALU_result  in  DATA_WIDTH  ALU result
- STG4_Mem_data  in  DATA_WIDTH  data memory read data
- STG4_Mem_Read  in  1  instruction is a load (ldw)
- STG4_Addr_Write_Reg  in  ADDR_WIDTH  destination register
- STG4_En_Write_Reg  in  1  decode-stage write request
- STG25_data_in  out  DATA_WIDTH  register-file write data
- STG25_addr_Write_Reg  out  ADDR_WIDTH  register-file write address
- STG25_En_Write_Reg  out  1  register-file write enable
- Fwd_Valid  out  1  Fwd_Addr/Fwd_Data hold the previous cycle's write
- Fwd_Addr  out  ADDR_WIDTH  address of previous write
- Fwd_Data  out  DATA_WIDTH  data of previous write
- Retired_Count  out  CNT_WIDTH  valid instructions retired
- Write_Count  out  CNT_WIDTH  register writes issued

## Operation
- Data select: STG4_Mem_Read=1 -> STG4_Mem_data, else STG4_ALU_result.
- Qualified write (qw) = STG4_Valid & STG4_En_Write_Reg & (STG4_Addr_Write_Reg != 0) & opcode not in {0x02 stw, 0x0C beq, 0x0D bne, 0x0E bgt, 0x0F ble, 0x3F jmp}. Suppression is enforced even if the decode stage requested a write.
- Capture (En_Pipeline=1): STG25_data_in <= selected data; STG25_addr_Write_Reg <= STG4_Addr_Write_Reg; STG25_En_Write_Reg <= qw.
- Stall (En_Pipeline=0): data and address hold; STG25_En_Write_Reg <= 0. Each write is issued for exactly one cycle; no duplicate writes during stalls.
- Forward register, every edge regardless of En_Pipeline: Fwd_Valid <= STG25_En_Write_Reg; when STG25_En_Write_Reg=1, Fwd_Addr <= STG25_addr_Write_Reg and Fwd_Data <= STG25_data_in, else both hold.
- Retired_Count increments on each capture with STG4_Valid=1. Write_Count increments on each capture with qw=1. Both wrap 2^CNT_WIDTH-1 -> 0 silently.
- No state machine beyond the stage register. Stall is an implicit state: En_Pipeline selects hold vs capture.

## Timing
- Latency: inputs sampled at rising edge N; STG25_* valid after edge N, and the decode stage writes its register file at edge N+1. Fwd_* reflects that write after edge N+1, for one cycle.
- Counters update at the same edge as the capture.
- Reset (reset=0, asynchronous, including mid-operation): every output is 0 immediately, including the counters and Fwd_*. The first capture occurs on the first rising edge with reset=1.
- Stall and resume: if En_Pipeline=0 at edge N and 1 at edge N+1, the inputs present at N+1 are captured. Inputs present only during the stall are lost; holding them is the upstream stage's job.
- Bubble (STG4_Valid=0) with En_Pipeline=1: data and address are captured, enable is 0, and no counter changes.
- Back-to-back writes to the same register: each is issued in its own cycle, in order.

## Test plan
- Reset: drive reset=0 mid-stream with STG25_En_Write_Reg=1 -> all outputs 0 before the next edge. Release; the first capture lands at the next edge.
- ALU vs load: add r3 with ALU_result=5, Mem_data=0xDEAD, Mem_Read=0 -> data=5, addr=3, en=1. Then ldw r4 with Mem_Read=1, Mem_data=0xDEAD -> data=0xDEAD, addr=4, en=1, Write_Count=2.
- Suppression: En_Write_Reg=1 with addr=0, then opcodes 0x02, 0x0C, 0x0F, 0x3F with addr=3 -> en=0 every cycle. Retired_Count increments 5 times; Write_Count is unchanged.
- Stall: capture addi r2 data=7, then En_Pipeline=0 for 3 cycles -> en=1 for one cycle then 0, data/addr stay 7/2, Fwd_Valid=1 for exactly one cycle with Fwd_Addr=2, Fwd_Data=7.
- Bubbles and wrap: STG4_Valid=0 for 4 cycles -> en=0 and counters frozen. Force Retired_Count to 0xFFFFFFFF (via CNT_WIDTH=4 build: 15) plus one valid capture -> 0.
